// File: rtl/mem_access_pkg.sv
// mem_access_pkg
// Shared types and constants for the memory access master.
//   state_e : access FSM states (IDLE / READ / WRITE)
//   op_e    : latched request opcode (FETCH / LOAD / STORE)
//   LAT_W   : width of the read-latency down-counter
//   op_is_data() : true for opcodes that address the data side of memory
package mem_access_pkg;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_FETCH = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } op_e;

  // Loads and stores use the data address and drive IorDsignal high.
  function automatic logic op_is_data(input op_e op);
    return (op != OP_FETCH);
  endfunction

endpackage

// File: rtl/mem_access_master_if.sv
// mem_access_master_if
// Bundles the request side (control unit / datapath) and the memory side
// of the unified instruction/data memory port.
//   Requests   : req_fetch, req_load, req_store, pc, data_addr, store_data
//   Memory in  : out_data
//   Memory out : address, PC, IorDsignal, MemRead, MemWrite, WriteData
//   Results    : ir, mdr, busy, done, err
// modport master : the access master itself
// modport slave  : the surrounding control unit, datapath and memory
interface mem_access_master_if;

  logic        req_fetch;
  logic        req_load;
  logic        req_store;
  logic [31:0] pc;
  logic [31:0] data_addr;
  logic [31:0] store_data;
  logic [31:0] out_data;

  logic [31:0] address;
  logic [31:0] PC;
  logic        IorDsignal;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] WriteData;

  logic [31:0] ir;
  logic [31:0] mdr;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    input  req_fetch, req_load, req_store, pc, data_addr, store_data, out_data,
    output address, PC, IorDsignal, MemRead, MemWrite, WriteData,
    output ir, mdr, busy, done, err
  );

  modport slave (
    output req_fetch, req_load, req_store, pc, data_addr, store_data, out_data,
    input  address, PC, IorDsignal, MemRead, MemWrite, WriteData,
    input  ir, mdr, busy, done, err
  );

endinterface

// File: rtl/mem_lat_counter.sv
// mem_lat_counter
// Loadable down-counter that times the memory read latency.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset (count cleared)
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : starting count, i.e. the read latency in cycles
//   expire   : high while the count equals 1, the last cycle of the read
module mem_lat_counter
  import mem_access_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic             expire
);

  logic [LAT_W-1:0] count_q;
  logic [LAT_W-1:0] count_d;

  // Count down towards zero and rest there; a load restarts the count.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - LAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == LAT_W'(1));

endmodule

// File: rtl/mem_access_master.sv
// mem_access_master
// Initiator side of the multicycle processor's unified memory port.
// Accepts fetch/load/store requests, drives the memory control signals,
// waits MEM_LATENCY cycles for read data and captures it into IR or MDR.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : mem_access_master_if.master (requests, memory port, results)
// Parameters:
//   MEM_LATENCY : cycles from MemRead assertion to valid out_data (1..15)
//   MEM_DEPTH   : memory size in words, used by the optional range check
// Build option:
//   MEM_RANGE_CHECK_EN : when defined, requests whose address is
//   >= MEM_DEPTH are rejected with a done+err pulse and no memory access.
module mem_access_master
  import mem_access_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int MEM_DEPTH   = 256
)(
  input  logic                clk,
  input  logic                rst,
  mem_access_master_if.master bus
);

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LATENCY);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] mdr_q, mdr_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        any_req;
  op_e         req_op;
  logic [31:0] req_addr;
  logic        req_out_of_range;
  logic        lat_load;
  logic        lat_expire;

  // Request arbitration: store beats load beats fetch; losers are dropped.
  always_comb begin
    any_req = bus.req_fetch | bus.req_load | bus.req_store;
    req_op  = OP_FETCH;
    if (bus.req_store) begin
      req_op = OP_STORE;
    end else if (bus.req_load) begin
      req_op = OP_LOAD;
    end
    req_addr = op_is_data(req_op) ? bus.data_addr : bus.pc;
  end

`ifdef MEM_RANGE_CHECK_EN
  assign req_out_of_range = (req_addr >= 32'(MEM_DEPTH));
`else
  assign req_out_of_range = 1'b0;
`endif

  mem_lat_counter u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (lat_load),
    .load_val (LAT_INIT),
    .expire   (lat_expire)
  );

  // Next-state logic. done/err default low so they only pulse for the
  // single cycle following a completion or rejection.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ir_d     = ir_q;
    mdr_d    = mdr_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    lat_load = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          op_d = req_op;
          if (op_is_data(req_op)) begin
            addr_d = bus.data_addr;
          end else begin
            pc_d = bus.pc;
          end
          if (req_op == OP_STORE) begin
            wdata_d = bus.store_data;
          end
          // A rejected request never leaves IDLE, so neither enable rises.
          if (req_out_of_range) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (req_op == OP_STORE) begin
            state_d = ST_WRITE;
          end else begin
            state_d  = ST_READ;
            lat_load = 1'b1;
          end
        end
      end

      // out_data is valid on the edge that ends the last latency cycle.
      ST_READ: begin
        if (lat_expire) begin
          if (op_q == OP_FETCH) begin
            ir_d = bus.out_data;
          end else begin
            mdr_d = bus.out_data;
          end
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_WRITE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_FETCH;
      pc_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ir_q    <= '0;
      mdr_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Memory controls decode straight from the registered state, so a reset
  // mid-access drops them in the very next cycle.
  assign bus.MemRead    = (state_q == ST_READ);
  assign bus.MemWrite   = (state_q == ST_WRITE);
  assign bus.IorDsignal = (state_q == ST_WRITE) ||
                          ((state_q == ST_READ) && op_is_data(op_q));
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.PC         = pc_q;
  assign bus.address    = addr_q;
  assign bus.WriteData  = wdata_q;
  assign bus.ir         = ir_q;
  assign bus.mdr        = mdr_q;

endmodule

// File: doc/mem_access_master.md
# mem_access_master

Initiator side of the multicycle processor's unified instruction/data memory port. It accepts fetch, load and store requests from the control unit and selects between the PC and data addresses. It drives `IorDsignal`, `MemRead`, `MemWrite` and `WriteData` into the memory, waits a fixed read latency, then captures `out_data` into the instruction register (IR) or the memory data register (MDR). It sits between the control FSM/datapath and the memory block.

## Interface
- `MEM_LATENCY`, 1: cycles from `MemRead` assertion to the edge at which `out_data` is valid; legal range 1..15.
- `MEM_DEPTH`, 256: number of words in memory; used only by the range check.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous, active-high
- `req_fetch`  in  1  request an instruction read at `pc`
- `req_load`  in  1  request a data read at `data_addr`
- `req_store`  in  1  request a data write of `store_data` at `data_addr`
- `pc`  in  32  word address of the instruction
- `data_addr`  in  32  word address for load/store (ALU result)
- `store_data`  in  32  store value
- `out_data`  in  32  memory read data
- `address`  out  32  data-side address to memory
- `PC`  out  32  instruction-side address to memory
- `IorDsignal`  out  1  0 = instruction access, 1 = data access
- `MemRead`  out  1  memory read enable
- `MemWrite`  out  1  memory write enable
- `WriteData`  out  32  memory write data
- `ir`  out  32  instruction register
- `mdr`  out  32  memory data register
- `busy`  out  1  access in progress; requests are ignored
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  one-cycle pulse with `done` when an access is rejected

## Operation
- States: IDLE, READ, WRITE.
- IDLE: samples requests. Priority when several requests are high: store > load > fetch; the losing requests are dropped (not queued). On acceptance, latch the address, the opcode and `store_data`.
- READ: `MemRead`=1. `IorDsignal`=0 for fetch and 1 for load. A latency counter loads `MEM_LATENCY` and decrements once per cycle. When it reaches 1, capture `out_data` into `ir` (fetch) or `mdr` (load) on that edge and go to IDLE.
- WRITE: `MemWrite`=1 and `IorDsignal`=1 for exactly one cycle, then go to IDLE.
- `done` is registered and is high in the first IDLE cycle after completion. A new request is accepted in that same cycle, so back-to-back accesses are supported.
- `busy` = (state != IDLE).
- Requests arriving while `busy` is high are ignored.
- `PC`, `address` and `WriteData` hold the latched values throughout an access. In IDLE they hold their last values.
- `ir` and `mdr` change only on a completed fetch or load respectively.
- Reset values: state IDLE; `PC`, `address`, `WriteData`, `ir`, `mdr` = 0; `IorDsignal`, `MemRead`, `MemWrite`, `busy`, `done`, `err` = 0.
- Reset mid-access: the state returns to IDLE on that edge, and `MemRead`/`MemWrite` are low in the next cycle. No capture occurs and no `done` is issued.

## Timing
- Request sampled at the edge ending cycle T.
- Read: `MemRead` is high during cycles T+1 .. T+`MEM_LATENCY`. Capture happens at the edge ending T+`MEM_LATENCY`. `done` is high in cycle T+`MEM_LATENCY`+1.
- Store: `MemWrite` is high in cycle T+1 only; `done` is high in T+2.
- Throughput: one read per `MEM_LATENCY`+1 cycles; one store per 2 cycles.

## Configuration
- `MEM_RANGE_CHECK_EN` defined:
  - An accepted request whose address is >= `MEM_DEPTH` does not assert `MemRead` or `MemWrite`.
  - The block goes to IDLE and pulses `done` and `err` in cycle T+1.
  - `ir` and `mdr` are unchanged.
- Undefined: `err` is tied to 0 and every address is passed through unchanged.

## Structure
- Package `mem_access_pkg`: state encoding (IDLE/READ/WRITE), opcode encoding (FETCH/LOAD/STORE), and the width constant for the latency counter (4 bits).
- Sub-module `mem_lat_counter`: loadable down-counter that pulses `expire` when its count reaches 1. The FSM, request arbitration and IR/MDR registers stay in the top level.

## Test plan
- Reset, then `req_fetch` with `pc`=0, memory word0=0x8C220003, `MEM_LATENCY`=1:
  - `MemRead`=1 and `IorDsignal`=0 in T+1.
  - `ir`=0x8C220003 and `done`=1 in T+2.
- `req_load` with `data_addr`=3, word3=0x0000ABCD, `MEM_LATENCY`=3:
  - `IorDsignal`=1 and `MemRead` high for 3 cycles.
  - `mdr`=0x0000ABCD and `done` in T+4.
  - `ir` unchanged.
- `req_store` with `data_addr`=5 and `store_data`=0xDEADBEEF:
  - `MemWrite` high for exactly one cycle, `done` in T+2.
  - A following load from 5 returns 0xDEADBEEF.
- All three requests high together: only the store executes. Then:
  - A fetch issued in the `done` cycle is accepted immediately.
  - A request during `busy` is ignored (no extra `done`).
- `rst` asserted during the second cycle of a 3-cycle load: `MemRead` is low in the next cycle, no `done` is issued, and `mdr`=0.
- With `MEM_RANGE_CHECK_EN` and `MEM_DEPTH`=256, a load at `data_addr`=300: no `MemRead`, `done`=`err`=1 in T+1, `mdr` unchanged.
